// File: rtl/onehot_pkg.sv
// Shared types and constants for the handshaked one-hot decoder.
// The state enum is also exported on the top-level debug port.
package onehot_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    ROT  = 2'd2
  } state_e;

  // Default map of unused codes for the 3-bit select configuration.
  localparam logic [7:0] DEFAULT_UNUSED_MASK = 8'b0000_0010;

endpackage

// File: rtl/onehot_next_sel.sv
// Combinational search for the next unmasked one-hot position above cur_i.
// The search wraps from the top bit to bit 0; an all-zero cur_i yields the lowest unmasked position.
module onehot_next_sel #(
  parameter int OUT_W = 8,
  localparam int IDX_W = $clog2(OUT_W)
) (
  input  logic [OUT_W-1:0] cur_i,
  input  logic [OUT_W-1:0] mask_i,
  output logic [OUT_W-1:0] next_o
);

  logic [IDX_W-1:0] base;
  logic [IDX_W-1:0] idx;
  logic             found;

  always_comb begin
    base = '0;
    // Start one above the current bit; the top bit wraps to index 0 by truncation.
    for (int i = 0; i < OUT_W; i++) begin
      if (cur_i[i]) begin
        base = IDX_W'(i + 1);
      end
    end

    next_o = '0;
    found  = 1'b0;
    idx    = '0;
    for (int off = 0; off < OUT_W; off++) begin
      idx = base + IDX_W'(off);
      if (!found && !mask_i[idx]) begin
        next_o[idx] = 1'b1;
        found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/onehot_dec_hs.sv
// One-hot decoder with valid/ready handshake, a rotate mode that walks the unmasked
// positions, and a saturating counter of accepted unused codes.
module onehot_dec_hs
  import onehot_pkg::*;
#(
  parameter int                          SEL_W       = 3,
  localparam int                         OUT_W       = 2 ** SEL_W,
  parameter logic [(2 ** SEL_W)-1:0]     UNUSED_MASK = DEFAULT_UNUSED_MASK,
  parameter int                          ERRCNT_W    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mode,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [SEL_W-1:0]    sel,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [OUT_W-1:0]    res,
  output logic                err,
  output logic [ERRCNT_W-1:0] err_cnt,
  output state_e              dbg_state
);

  // Handshake: a transfer on either side happens in a cycle where its valid and
  // ready are both high at the rising edge; valid never depends on ready here.

  if (&UNUSED_MASK) begin : g_bad_mask
    $error("onehot_dec_hs: UNUSED_MASK marks every code unused");
  end

  state_e               state_q, state_d;
  logic [OUT_W-1:0]     res_q, res_d;
  logic                 err_q, err_d;
  logic [ERRCNT_W-1:0]  err_cnt_q, err_cnt_d;

  logic [OUT_W-1:0]     cur_sel;
  logic [OUT_W-1:0]     next_hot;
  logic [OUT_W-1:0]     sel_hot;
  logic                 accept;
  logic                 sel_unused;

  assign in_ready   = !mode && ((state_q == IDLE) || ((state_q == HOLD) && out_ready));
  assign accept     = in_valid && in_ready;
  assign sel_unused = UNUSED_MASK[sel];
  assign sel_hot    = OUT_W'(1) << sel;

  // res_q keeps a stale value in IDLE, so hide it to restart rotation from the bottom.
  assign cur_sel = (state_q == IDLE) ? '0 : res_q;

  onehot_next_sel #(
    .OUT_W (OUT_W)
  ) u_next_sel (
    .cur_i  (cur_sel),
    .mask_i (UNUSED_MASK),
    .next_o (next_hot)
  );

  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    err_d   = 1'b0;

    if (accept) begin
      if (sel_unused) begin
        err_d   = 1'b1;
        state_d = IDLE;
      end else begin
        res_d   = sel_hot;
        state_d = HOLD;
      end
    end else begin
      case (state_q)
        IDLE: begin
          if (mode) begin
            res_d   = next_hot;
            state_d = ROT;
          end
        end
        HOLD, ROT: begin
          if (out_ready) begin
            if (mode) begin
              res_d   = next_hot;
              state_d = ROT;
            end else begin
              state_d = IDLE;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_d && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + ERRCNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      res_q     <= '0;
      err_q     <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      res_q     <= res_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign out_valid = (state_q != IDLE);
  assign res       = res_q;
  assign err       = err_q;
  assign err_cnt   = err_cnt_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_onehot_dec_hs.sv
// Bench for onehot_dec_hs: directed scenarios, randomized traffic against a
// behavioural model, and a narrow-counter instance for saturation.
module tb_onehot_dec_hs;
  import onehot_pkg::*;

  localparam int         OUT_W   = 8;
  localparam logic [7:0] MASK    = 8'h02;
  localparam int         CNT_MAX = 255;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT (default parameters) ----------------
  logic       rst, mode, in_valid, out_ready;
  logic [2:0] sel;
  logic       in_ready, out_valid, err;
  logic [7:0] res, err_cnt;
  state_e     dbg_state;

  onehot_dec_hs u_dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sel       (sel),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res       (res),
    .err       (err),
    .err_cnt   (err_cnt),
    .dbg_state (dbg_state)
  );

  // ---------------- DUT with a 2-bit error counter ----------------
  logic       rst2, mode2, in_valid2, out_ready2;
  logic [2:0] sel2;
  logic       in_ready2, out_valid2, err2;
  logic [7:0] res2;
  logic [1:0] err_cnt2;
  state_e     dbg_state2;

  onehot_dec_hs #(.ERRCNT_W(2)) u_dut2 (
    .clk       (clk),
    .rst       (rst2),
    .mode      (mode2),
    .in_valid  (in_valid2),
    .in_ready  (in_ready2),
    .sel       (sel2),
    .out_valid (out_valid2),
    .out_ready (out_ready2),
    .res       (res2),
    .err       (err2),
    .err_cnt   (err_cnt2),
    .dbg_state (dbg_state2)
  );

  // ---------------- scoreboard counters ----------------
  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  bit m_busy;   // a result is being presented to the consumer
  bit m_rot;    // the presented result came from rotation
  int m_idx;    // bit position of res, -1 means all zero
  bit m_err;
  int m_errs;

  function automatic int next_free(input int from);
    int j;
    for (int k = 1; k <= OUT_W; k++) begin
      j = (from + k) % OUT_W;
      if (!MASK[j]) return j;
    end
    return from;
  endfunction

  function automatic bit model_ready();
    return (mode == 1'b0) && (!m_busy || (!m_rot && out_ready));
  endfunction

  function automatic logic [7:0] model_res();
    logic [7:0] one;
    one = 8'h01;
    return (m_idx < 0) ? 8'h00 : (one << m_idx);
  endfunction

  task automatic model_update();
    bit acc;
    if (rst) begin
      m_busy = 0; m_rot = 0; m_idx = -1; m_err = 0; m_errs = 0;
      return;
    end
    acc   = in_valid && model_ready();
    m_err = 0;
    if (acc) begin
      if (MASK[sel]) begin
        m_err  = 1;
        m_busy = 0;
        if (m_errs < CNT_MAX) m_errs++;
      end else begin
        m_idx  = int'(sel);
        m_busy = 1;
        m_rot  = 0;
      end
    end else if (!m_busy) begin
      if (mode) begin
        m_idx  = next_free(-1);
        m_busy = 1;
        m_rot  = 1;
      end
    end else if (out_ready) begin
      if (mode) begin
        m_idx = next_free(m_idx);
        m_rot = 1;
      end else begin
        m_busy = 0;
      end
    end
  endtask

  // One clock: check in_ready before the edge, advance the model, check registered outputs after.
  task automatic step();
    #1;
    if (!rst) check("in_ready", 32'(in_ready), 32'(model_ready()));
    @(posedge clk);
    model_update();
    #1;
    check("res",       32'(res),       32'(model_res()));
    check("out_valid", 32'(out_valid), 32'(m_busy));
    check("err",       32'(err),       32'(m_err));
    check("err_cnt",   32'(err_cnt),   32'(m_errs));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] rot_seq [8];
    logic [1:0] sat_seq [5];
    rot_seq = '{8'h01, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};
    sat_seq = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};

    rst = 1; mode = 0; in_valid = 0; sel = 0; out_ready = 0;
    rst2 = 1; mode2 = 0; in_valid2 = 0; sel2 = 3'd1; out_ready2 = 1;
    m_busy = 0; m_rot = 0; m_idx = -1; m_err = 0; m_errs = 0;

    step();
    step();
    check("rst_res",     32'(res),       32'h0);
    check("rst_out_vld", 32'(out_valid), 32'h0);
    check("rst_err_cnt", 32'(err_cnt),   32'h0);

    // Decode of a used code, then drain.
    rst = 0; mode = 0; out_ready = 1;
    #1 check("ready_after_rst", 32'(in_ready), 32'h1);
    in_valid = 1; sel = 3'd5;
    step();
    check("dec5_res",   32'(res),       32'h20);
    check("dec5_valid", 32'(out_valid), 32'h1);
    in_valid = 0;
    step();
    check("dec5_idle", 32'(out_valid), 32'h0);

    // Unused code: error pulse, result untouched.
    in_valid = 1; sel = 3'd1;
    step();
    check("unused_err",     32'(err),       32'h1);
    check("unused_cnt",     32'(err_cnt),   32'h1);
    check("unused_res",     32'(res),       32'h20);
    check("unused_out_vld", 32'(out_valid), 32'h0);
    in_valid = 0;
    step();
    check("unused_err_gone", 32'(err), 32'h0);

    // Backpressure in HOLD, then back-to-back accept on release.
    in_valid = 1; sel = 3'd2; out_ready = 0;
    step();
    sel = 3'd6;
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_ready", 32'(in_ready), 32'h0);
      check("bp_res",   32'(res),      32'h04);
    end
    out_ready = 1;
    step();
    check("b2b_res", 32'(res), 32'h40);
    in_valid = 0;
    step();

    // Rotation skipping the masked code, with wrap.
    mode = 1;
    for (int i = 0; i < 8; i++) begin
      step();
      check("rot_seq", 32'(res), 32'(rot_seq[i]));
    end
    repeat (5) step();
    check("rot_at_40", 32'(res), 32'h40);

    // Reset in ROT drops the result.
    rst = 1;
    step();
    check("rst_rot_res",     32'(res),       32'h0);
    check("rst_rot_out_vld", 32'(out_valid), 32'h0);
    check("rst_rot_cnt",     32'(err_cnt),   32'h0);
    rst = 0; mode = 0;

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      rst       = ($urandom_range(0, 59) == 0);
      mode      = ($urandom_range(0, 3) == 0);
      in_valid  = $urandom_range(0, 1);
      sel       = 3'($urandom_range(0, 7));
      out_ready = ($urandom_range(0, 9) < 7);
      step();
    end
    rst = 0; mode = 0; in_valid = 0; out_ready = 1;
    step();

    // Saturation of a 2-bit error counter.
    rst2 = 0; in_valid2 = 1; sel2 = 3'd1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("sat_err",     32'(err2),     32'h1);
      check("sat_err_cnt", 32'(err_cnt2), 32'(sat_seq[i]));
    end
    in_valid2 = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/onehot_dec_hs.md
ONEHOT_DEC_HS -- requirements
Module: onehot_dec_hs

Interface
REQ-001 SHALL have parameter SEL_W, default 3, meaning select width; OUT_W = 2**SEL_W is derived and not overridable.
REQ-002 SHALL have parameter UNUSED_MASK, OUT_W bits, default 8'b0000_0010; bit k = 1 marks code k as unused.
REQ-003 SHALL have parameter ERRCNT_W, default 8, meaning error counter width.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 mode  input  1  0 = DECODE, 1 = ROTATE.
REQ-007 in_valid  input  1  sel is valid.
REQ-008 in_ready  output  1  block accepts sel this cycle.
REQ-009 sel  input  SEL_W  code to decode.
REQ-010 out_valid  output  1  res is valid.
REQ-011 out_ready  input  1  consumer accepts res.
REQ-012 res  output  OUT_W  registered one-hot result.
REQ-013 err  output  1  one-cycle pulse on an unused code accepted.
REQ-014 err_cnt  output  ERRCNT_W  saturating count of err pulses.

Function
REQ-015 State machine SHALL have states IDLE, HOLD and ROT; out_valid = 1 exactly in HOLD and ROT.
REQ-016 in_ready SHALL equal (mode == 0) && (state == IDLE || (state == HOLD && out_ready)).
REQ-017 Accept SHALL mean in_valid && in_ready; an accepted used code k SHALL load res = 1 << k and enter HOLD the next cycle (latency 1).
REQ-018 An accepted unused code SHALL leave res unchanged, pulse err the next cycle and go to IDLE; if a HOLD handshake happens in the same cycle, the handshake SHALL complete.
REQ-019 err_cnt SHALL increment per err pulse and saturate at all-ones.
REQ-020 IDLE with mode = 1 SHALL go to ROT with res = lowest unmasked one-hot position.
REQ-021 HOLD with out_ready and no accept SHALL go to ROT if mode = 1, with res = next unmasked position above the current one; otherwise it SHALL go to IDLE.
REQ-022 ROT with out_ready and mode = 1 SHALL advance res to the next unmasked position above the current one, wrapping from bit OUT_W-1 to bit 0; with mode = 0 it SHALL go to IDLE.
REQ-023 While out_valid = 1 && out_ready = 0, res and state SHALL stay stable, whatever mode or in_valid do.
REQ-024 In IDLE, res SHALL hold its last value; consumers SHALL ignore res while out_valid = 0.
REQ-025 res SHALL never have more than one bit set and SHALL never select a masked position.
REQ-026 UNUSED_MASK with all bits set SHALL be rejected at elaboration.

Reset
REQ-027 With rst = 1 at a clock edge: state = IDLE, res = 0, out_valid = 0, err = 0, err_cnt = 0.
REQ-028 Reset SHALL override every other input, including mid-handshake and in ROT; a pending result SHALL be dropped.
REQ-029 in_ready SHALL be 1 in the first cycle after reset release if mode = 0.

Structure
REQ-030 Package onehot_pkg SHALL hold the state enum (IDLE, HOLD, ROT) and the default-mask constant.
REQ-031 The next-unmasked search (current one-hot, mask -> next one-hot, wrap) SHALL be a sub-module onehot_next_sel, purely combinational.
REQ-032 RTL SHALL contain no x assignments; every output SHALL be deterministic.

Verification (SEL_W = 3, UNUSED_MASK = 8'h02)
REQ-033 rst, then mode = 0, sel = 3'd5 valid, out_ready = 1 -> next cycle res = 8'h20, out_valid = 1; following cycle IDLE.
REQ-034 sel = 3'd1 accepted -> err = 1 for one cycle, err_cnt = 1, res unchanged, out_valid = 0.
REQ-035 HOLD with res = 8'h04, out_ready = 0 for 5 cycles, new sel offered -> in_ready = 0 and res = 8'h04 stable; release -> new sel accepted in the same cycle (back-to-back).
REQ-036 mode = 1 from IDLE, out_ready = 1 -> res sequence 01, 04, 08, 10, 20, 40, 80, 01 (02 is skipped, and res wraps).
REQ-037 rst asserted in ROT with res = 8'h40 -> next cycle res = 0, out_valid = 0, err_cnt = 0.
REQ-038 ERRCNT_W = 2, five unused codes accepted -> err_cnt reads 1, 2, 3, 3, 3.
